// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding and address-field width helpers for icache_direct.
package icache_pkg;
    typedef enum logic {IDLE, REFILL} state_t;
    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction
    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction
    function automatic int tag_bits(input int lines, input int line_words);
        return 30 - $clog2(lines) - $clog2(line_words);
    endfunction
endpackage

// File: rtl/icache_store.sv
// icache_store: valid/tag/data arrays; combinational lookup, word/tag writes, global invalidate.
//   rd_idx/rd_off/rd_tag -> hit, rd_word : lookup port
//   wr_en/wr_idx/wr_off/wr_data          : refill word write
//   tag_we/tag_val/set_valid              : tag write, optionally marking the line valid
//   inval                                 : clear every valid bit
module icache_store
    import icache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    localparam int OW = off_bits(LINE_WORDS),
    localparam int IW = idx_bits(LINES),
    localparam int TW = tag_bits(LINES, LINE_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] rd_idx,
    input  logic [OW-1:0] rd_off,
    input  logic [TW-1:0] rd_tag,
    output logic          hit,
    output logic [31:0]   rd_word,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [OW-1:0] wr_off,
    input  logic [31:0]   wr_data,
    input  logic          tag_we,
    input  logic [TW-1:0] tag_val,
    input  logic          set_valid,
    input  logic          inval
);
    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    logic [31:0]      data [LINES][LINE_WORDS];

    assign hit     = valid[rd_idx] && tags[rd_idx] == rd_tag;
    assign rd_word = data[rd_idx][rd_off];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (inval) valid <= '0;
            if (tag_we && set_valid) valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) data[wr_idx][wr_off] <= wr_data;
        if (tag_we) tags[wr_idx] <= tag_val;
    end
endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with in-order line refill.
//   cpu_addr/cpu_req/cpu_ready : fetch request handshake
//   cpu_rdata/cpu_valid        : one-cycle response pulse per accepted request
//   flush                      : invalidate all lines (fence.i)
//   mem_addr/mem_req           : refill beat request to the interconnect
//   mem_rdata/mem_ready        : refill beat data and completion
module icache_direct
    import icache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_req,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_valid,
    input  logic        flush,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam int OW = off_bits(LINE_WORDS);
    localparam int IW = idx_bits(LINES);
    localparam int TW = tag_bits(LINES, LINE_WORDS);
    localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);

    state_t        state, state_n;
    logic [OW-1:0] cnt, off_q;
    logic [IW-1:0] idx_q;
    logic [TW-1:0] tag_q;
    logic [31:0]   crit, rd_word;
    logic          flush_pend, hit, accept, beat, last;

    wire [OW-1:0] a_off = cpu_addr[2 +: OW];
    wire [IW-1:0] a_idx = cpu_addr[2 + OW +: IW];
    wire [TW-1:0] a_tag = cpu_addr[31 -: TW];

    assign cpu_ready = state == IDLE && !reset && !flush;
    assign accept    = cpu_req && cpu_ready;
    assign beat      = state == REFILL && mem_ready;
    assign last      = beat && cnt == LAST;

    icache_store #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) u_store (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (a_idx),
        .rd_off    (a_off),
        .rd_tag    (a_tag),
        .hit       (hit),
        .rd_word   (rd_word),
        .wr_en     (beat),
        .wr_idx    (idx_q),
        .wr_off    (cnt),
        .wr_data   (mem_rdata),
        .tag_we    (last),
        .tag_val   (tag_q),
        .set_valid (!(flush_pend || flush)),
        .inval     (flush)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        mem_req  = 1'b0;
        mem_addr = '0;
        if (state == IDLE) begin
            if (accept && !hit) state_n = REFILL;
        end else begin
            mem_req  = 1'b1;
            mem_addr = {tag_q, idx_q, cnt, 2'b00};
            if (last) state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            flush_pend <= 1'b0;
            cpu_valid  <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_valid <= (accept && hit) || last;
            if (accept && hit) cpu_rdata <= rd_word;
            else if (last)     cpu_rdata <= cnt == off_q ? mem_rdata : crit;
            if (accept) begin
                tag_q <= a_tag;
                idx_q <= a_idx;
                off_q <= a_off;
                cnt   <= '0;
            end else if (beat) begin
                cnt <= cnt + OW'(1);
            end
            if (beat && cnt == off_q) crit <= mem_rdata;
            // a flush seen anywhere in the refill keeps the new line invalid
            flush_pend <= state == REFILL && !last && (flush_pend || flush);
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed self-checking bench for icache_direct.
module tb_icache_direct;
    logic        clk = 1'b0;
    logic        reset, cpu_req, flush, mem_ready;
    logic [31:0] cpu_addr, mem_rdata;
    logic        cpu_ready, cpu_valid, mem_req;
    logic [31:0] cpu_rdata, mem_addr;
    int          n_tests = 0;
    int          n_fail = 0;

    icache_direct dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_req   (cpu_req),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_valid (cpu_valid),
        .flush     (flush),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    // backing memory: word at address a is {a[11:8], 8'hA0 + word-in-line}
    always_comb mem_rdata = {20'h0, mem_addr[11:8], 8'hA0 + {6'h0, mem_addr[3:2]}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_miss(input string tag, input logic [31:0] a, input logic [31:0] exp);
        int lat;
        cpu_addr = a;
        cpu_req  = 1'b1;
        step();
        cpu_req  = 1'b0;
        cpu_addr = 32'hDEAD_BEE0;
        check({tag, "_mreq"}, {31'h0, mem_req}, 32'h1);
        lat = 1;
        while (!cpu_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd5);
        check({tag, "_data"}, cpu_rdata, exp);
    endtask

    initial begin
        logic [31:0] exp_addr [4];
        reset = 1'b1; cpu_req = 1'b0; flush = 1'b0; mem_ready = 1'b1; cpu_addr = '0;
        step();
        step();
        check("rst_ready", {31'h0, cpu_ready}, 32'h0);
        check("rst_valid", {31'h0, cpu_valid}, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_mreq", {31'h0, mem_req}, 32'h0);
        check("rst_maddr", mem_addr, 32'h0);
        reset = 1'b0;
        #1;
        check("idle_ready", {31'h0, cpu_ready}, 32'h1);

        // first miss on 0x100: beats at 0x100..0x10C, response on cycle 5
        exp_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};
        cpu_addr = 32'h100;
        cpu_req  = 1'b1;
        step();
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("m1_maddr", mem_addr, exp_addr[i]);
            check("m1_ready", {31'h0, cpu_ready}, 32'h0);
            check("m1_nvalid", {31'h0, cpu_valid}, 32'h0);
            step();
        end
        check("m1_valid", {31'h0, cpu_valid}, 32'h1);
        check("m1_data", cpu_rdata, 32'h1A0);
        check("m1_mreq_off", {31'h0, mem_req}, 32'h0);
        check("m1_ready_back", {31'h0, cpu_ready}, 32'h1);

        // repeat hit accepted in the response cycle
        cpu_addr = 32'h100;
        cpu_req  = 1'b1;
        step();
        cpu_req = 1'b0;
        check("hit_valid", {31'h0, cpu_valid}, 32'h1);
        check("hit_data", cpu_rdata, 32'h1A0);
        check("hit_mreq", {31'h0, mem_req}, 32'h0);
        step();
        check("hit_pulse", {31'h0, cpu_valid}, 32'h0);

        // back-to-back hits across the line
        cpu_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 32'h100 + 32'(i * 4);
            step();
            check("b2b_valid", {31'h0, cpu_valid}, 32'h1);
            check("b2b_data", cpu_rdata, 32'h1A0 + 32'(i));
            check("b2b_mreq", {31'h0, mem_req}, 32'h0);
        end
        cpu_req = 1'b0;
        step();
        check("b2b_end", {31'h0, cpu_valid}, 32'h0);

        // miss on 0x208 with a 3-cycle stall before beat 1
        cpu_addr = 32'h208;
        cpu_req  = 1'b1;
        step();
        cpu_req = 1'b0;
        check("st_a0", mem_addr, 32'h200);
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("st_hold_addr", mem_addr, 32'h204);
            check("st_hold_req", {31'h0, mem_req}, 32'h1);
            step();
        end
        mem_ready = 1'b1;
        check("st_a1", mem_addr, 32'h204);
        step();
        check("st_a2", mem_addr, 32'h208);
        step();
        check("st_a3", mem_addr, 32'h20C);
        check("st_nvalid", {31'h0, cpu_valid}, 32'h0);
        step();
        check("st_valid", {31'h0, cpu_valid}, 32'h1);
        check("st_data", cpu_rdata, 32'h2A2);

        // conflicting lines 0x100 / 0x500 share index 0
        do_miss("alt0", 32'h10C, 32'h1A3);
        do_miss("alt1", 32'h504, 32'h5A1);
        do_miss("alt2", 32'h108, 32'h1A2);
        do_miss("alt3", 32'h50C, 32'h5A3);

        // flush during beat 1 of a refill: response delivered, line left invalid
        cpu_addr = 32'h300;
        cpu_req  = 1'b1;
        step();
        cpu_req = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("fl_nvalid", {31'h0, cpu_valid}, 32'h0);
        step();
        check("fl_valid", {31'h0, cpu_valid}, 32'h1);
        check("fl_data", cpu_rdata, 32'h3A0);
        do_miss("fl_remiss", 32'h304, 32'h3A1);

        // flush in IDLE blocks a coincident request and invalidates
        cpu_addr = 32'h300;
        cpu_req  = 1'b1;
        flush    = 1'b1;
        #1;
        check("fli_ready", {31'h0, cpu_ready}, 32'h0);
        step();
        cpu_req = 1'b0;
        flush   = 1'b0;
        check("fli_nvalid", {31'h0, cpu_valid}, 32'h0);
        check("fli_nmreq", {31'h0, mem_req}, 32'h0);
        do_miss("fli_remiss", 32'h308, 32'h3A2);

        // reset mid-refill: no response, valid bits cleared
        cpu_addr = 32'h100;
        cpu_req  = 1'b1;
        step();
        cpu_req = 1'b0;
        step();
        step();
        check("rr_pre_addr", mem_addr, 32'h108);
        reset = 1'b1;
        step();
        check("rr_mreq", {31'h0, mem_req}, 32'h0);
        check("rr_maddr", mem_addr, 32'h0);
        check("rr_valid", {31'h0, cpu_valid}, 32'h0);
        check("rr_ready", {31'h0, cpu_ready}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_noresp", {31'h0, cpu_valid}, 32'h0);
        end
        do_miss("rr_old", 32'h30C, 32'h3A3);
        do_miss("rr_new", 32'h100, 32'h1A0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
